mdu_seq: RTL and testbench

MDU_SEQ -- requirements
Module: mdu_seq

---
 rtl/mdu_seq.sv | 153 +++++++++++++++
 tb/tb_mdu_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// mdu_seq: sequential RISC-V M-extension unit.
// Multiplies complete one cycle after accept. Divides use a restoring
// shift-subtract loop that produces one quotient bit per cycle, followed by a
// sign fix-up cycle. Divide-by-zero and signed overflow finish in one cycle.
//
// Ports
//   clk_i        clock, all state updates on the rising edge
//   rst_i        synchronous active-high reset
//   req_i        operation request
//   operator_i   funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   operand_a_i  rs1 (dividend / multiplicand)
//   operand_b_i  rs2 (divisor / multiplier)
//   kill_i       flush, aborts any in-flight operation
//   ready_o      a request can be accepted this cycle
//   busy_o       divide in progress (stall request)
//   valid_o      result_o valid this cycle (one-cycle pulse)
//   result_o     result, held until the next operation completes
module mdu_seq #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic [2:0]            operator_i,
  input  logic [WORD_WIDTH-1:0] operand_a_i,
  input  logic [WORD_WIDTH-1:0] operand_b_i,
  input  logic                  kill_i,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic [WORD_WIDTH-1:0] result_o
);

  localparam int W = WORD_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIXUP, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [4:0]     cnt_q;
  logic           is_rem_q, is_sgn_q, neg_a_q, neg_b_q;
  logic [W-1:0]   quo_q, rem_q, dvs_q, result_q;

  function automatic logic [W-1:0] negate(input logic [W-1:0] x);
    return ~x + W'(1);
  endfunction

  function automatic logic [W-1:0] magnitude(input logic [W-1:0] x, input logic sgn);
    return (sgn && x[W-1]) ? negate(x) : x;
  endfunction

  logic accept, is_div, div_sgn, div_zero, div_ovf;

  assign ready_o  = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy_o   = (state_q == S_DIV) || (state_q == S_FIXUP);
  assign valid_o  = (state_q == S_DONE);
  assign result_o = result_q;

  assign accept   = req_i && ready_o && !kill_i;
  assign is_div   = operator_i[2];
  assign div_sgn  = !operator_i[0];
  assign div_zero = (operand_b_i == '0);
  assign div_ovf  = div_sgn && (operand_a_i == {1'b1, {(W-1){1'b0}}})
                  && (operand_b_i == {W{1'b1}});

  // Multiply: operands sign- or zero-extended to 2W, product kept mod 2^2W.
  logic               mul_a_sgn, mul_b_sgn;
  logic signed [2*W-1:0] mul_a, mul_b, mul_p;
  logic [W-1:0]       mul_res;

  assign mul_a_sgn = (operator_i[1:0] != 2'b11);
  assign mul_b_sgn = (operator_i[1] == 1'b0);
  assign mul_a     = {{W{mul_a_sgn & operand_a_i[W-1]}}, operand_a_i};
  assign mul_b     = {{W{mul_b_sgn & operand_b_i[W-1]}}, operand_b_i};
  assign mul_p     = mul_a * mul_b;
  assign mul_res   = (operator_i[1:0] == 2'b00) ? mul_p[W-1:0] : mul_p[2*W-1:W];

  // Restoring divide step: shift the next dividend bit into the partial
  // remainder and subtract the divisor when it fits.
  logic [W:0] shift_rem, diff;
  assign shift_rem = {rem_q, quo_q[W-1]};
  assign diff      = shift_rem - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept)
          state_d = (!is_div || div_zero || div_ovf) ? S_DONE : S_DIV;
        else if (state_q == S_DONE)
          state_d = S_IDLE;
      end
      S_DIV:   if (cnt_q == 5'd31) state_d = S_FIXUP;
      S_FIXUP: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (kill_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_rem_q <= 1'b0;
      is_sgn_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (kill_i) begin
        cnt_q <= '0;
      end else if (accept) begin
        // Accept: capture operation, resolve single-cycle results.
        is_rem_q <= operator_i[1];
        is_sgn_q <= div_sgn;
        neg_a_q  <= operand_a_i[W-1];
        neg_b_q  <= operand_b_i[W-1];
        cnt_q    <= '0;
        if (!is_div)
          result_q <= mul_res;
        else if (div_zero)
          result_q <= operator_i[1] ? operand_a_i : {W{1'b1}};
        else if (div_ovf)
          result_q <= operator_i[1] ? '0 : operand_a_i;
        else begin
          quo_q <= magnitude(operand_a_i, div_sgn);
          dvs_q <= magnitude(operand_b_i, div_sgn);
          rem_q <= '0;
        end
      end else if (state_q == S_DIV) begin
        // Iterate: one quotient bit per cycle.
        if (!diff[W]) begin
          rem_q <= diff[W-1:0];
          quo_q <= {quo_q[W-2:0], 1'b1};
        end else begin
          rem_q <= shift_rem[W-1:0];
          quo_q <= {quo_q[W-2:0], 1'b0};
        end
        cnt_q <= cnt_q + 5'd1;
      end else if (state_q == S_FIXUP) begin
        // Fix-up: restore signs; quotient truncates toward zero.
        if (is_rem_q)
          result_q <= (is_sgn_q && neg_a_q) ? negate(rem_q) : rem_q;
        else
          result_q <= (is_sgn_q && (neg_a_q != neg_b_q)) ? negate(quo_q) : quo_q;
      end
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: multiplies, divides with latency, special
// cases, kill, back-to-back issue and mid-divide reset.
module tb_mdu_seq;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0;
  logic [2:0]  operator_i = 3'd0;
  logic [31:0] operand_a_i = '0;
  logic [31:0] operand_b_i = '0;
  logic        kill_i = 1'b0;
  logic        ready_o, busy_o, valid_o;
  logic [31:0] result_o;

  int errors = 0;
  int checks = 0;

  localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010,
                         OP_MULHU = 3'b011, OP_DIV = 3'b100, OP_DIVU = 3'b101,
                         OP_REM = 3'b110, OP_REMU = 3'b111;

  mdu_seq #(.WORD_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .operator_i(operator_i),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .kill_i(kill_i),
    .ready_o(ready_o), .busy_o(busy_o), .valid_o(valid_o), .result_o(result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_i = 1'b1;
    operator_i = op;
    operand_a_i = a;
    operand_b_i = b;
  endtask

  // Issue now (cycle 0), return result and the cycle valid_o rose (99 = never).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    issue(op, a, b);
    lat = 0;
    do begin
      tick();
      lat++;
      if (lat == 1) req_i = 1'b0;
    end while (!valid_o && lat < 40);
    res = result_o;
    if (!valid_o) lat = 99;
  endtask

  initial begin
    logic [31:0] r;
    int lat;
    int vcount;

    // Reset
    tick();
    tick();
    rst_i = 1'b0;
    chk("rst_ready", {31'd0, ready_o}, 32'd1);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_result", result_o, 32'd0);

    // Multiplies
    run_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, r, lat);
    chk("mul_lat", lat, 32'd1);
    chk("mul_res", r, 32'hFFFF_FFEB);
    tick();
    chk("mul_valid_pulse", {31'd0, valid_o}, 32'd0);
    chk("mul_hold", result_o, 32'hFFFF_FFEB);
    run_op(OP_MULH, 32'h8000_0000, 32'h8000_0000, r, lat);
    chk("mulh_res", r, 32'h4000_0000);
    run_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat);
    chk("mulhu_res", r, 32'hFFFF_FFFE);
    run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'd2, r, lat);
    chk("mulhsu_res", r, 32'hFFFF_FFFF);
    chk("mulhsu_lat", lat, 32'd1);
    tick();

    // DIV -7/2 with a MUL held on req_i throughout the divide
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    tick();
    issue(OP_MUL, 32'd6, 32'd7);
    for (int c = 1; c <= 33; c++) begin
      chk($sformatf("div_flags_c%0d", c), {29'd0, busy_o, valid_o, ready_o}, 32'b100);
      chk($sformatf("div_hold_c%0d", c), result_o, 32'hFFFF_FFFF);
      tick();
    end
    chk("div_c34_flags", {29'd0, busy_o, valid_o, ready_o}, 32'b011);
    chk("div_res", result_o, 32'hFFFF_FFFD);
    tick();
    req_i = 1'b0;
    chk("b2b_valid", {31'd0, valid_o}, 32'd1);
    chk("b2b_res", result_o, 32'd42);
    tick();
    chk("b2b_pulse", {31'd0, valid_o}, 32'd0);
    chk("b2b_hold", result_o, 32'd42);

    // More divides
    run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, r, lat);
    chk("rem_res", r, 32'hFFFF_FFFF);
    chk("rem_lat", lat, 32'd34);
    run_op(OP_DIVU, 32'd100, 32'd7, r, lat);
    chk("divu_res", r, 32'd14);
    chk("divu_lat", lat, 32'd34);
    run_op(OP_REMU, 32'd100, 32'd7, r, lat);
    chk("remu_res", r, 32'd2);
    run_op(OP_DIV, 32'd20, 32'hFFFF_FFFD, r, lat);
    chk("div_negb_res", r, 32'hFFFF_FFFA);
    run_op(OP_REM, 32'd20, 32'hFFFF_FFFD, r, lat);
    chk("rem_negb_res", r, 32'd2);

    // Special-case divides
    run_op(OP_DIVU, 32'd5, 32'd0, r, lat);
    chk("divu0_res", r, 32'hFFFF_FFFF);
    chk("divu0_lat", lat, 32'd1);
    run_op(OP_REM, 32'd5, 32'd0, r, lat);
    chk("rem0_res", r, 32'd5);
    chk("rem0_lat", lat, 32'd1);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
    chk("divovf_res", r, 32'h8000_0000);
    chk("divovf_lat", lat, 32'd1);
    run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
    chk("removf_res", r, 32'd0);
    tick();

    // Kill overrides a request in IDLE
    issue(OP_MUL, 32'd9, 32'd9);
    kill_i = 1'b1;
    tick();
    req_i = 1'b0;
    kill_i = 1'b0;
    chk("kill_req_valid", {31'd0, valid_o}, 32'd0);
    chk("kill_req_ready", {31'd0, ready_o}, 32'd1);

    // Kill at cycle 10 of a divide
    issue(OP_DIV, 32'd100, 32'd7);
    tick();
    req_i = 1'b0;
    repeat (9) tick();
    kill_i = 1'b1;
    tick();
    kill_i = 1'b0;
    chk("kill_flags", {29'd0, busy_o, valid_o, ready_o}, 32'b001);
    vcount = 0;
    repeat (40) begin
      if (valid_o) vcount++;
      tick();
    end
    chk("kill_no_valid", vcount, 32'd0);
    run_op(OP_MUL, 32'd3, 32'd4, r, lat);
    chk("post_kill_mul", r, 32'd12);
    chk("post_kill_lat", lat, 32'd1);
    tick();

    // Reset at cycle 20 of a divide, with kill and a request asserted
    issue(OP_DIVU, 32'd100, 32'd7);
    tick();
    req_i = 1'b0;
    repeat (19) tick();
    rst_i = 1'b1;
    kill_i = 1'b1;
    issue(OP_MUL, 32'd3, 32'd4);
    tick();
    rst_i = 1'b0;
    kill_i = 1'b0;
    req_i = 1'b0;
    chk("midrst_flags", {29'd0, busy_o, valid_o, ready_o}, 32'b001);
    chk("midrst_result", result_o, 32'd0);
    vcount = 0;
    repeat (40) begin
      if (valid_o) vcount++;
      tick();
    end
    chk("midrst_no_valid", vcount, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
